traffic_light_ctrl: RTL

- Sequential controller for a two-road intersection: road A and road B, each with two vehicle sensors (sa1/sa2, sb1/sb2) and a red/orange/green lamp set.
- Replaces the purely combinational sensor-to-lamp mapping with a timed FSM: minimum green, gap-out/max-out, fixed orange and all-red clearance.
- Adds a maintenance flashing-orange mode.
- Sits between the raw sensor inputs and the lamp drivers.

---
 rtl/traffic_pkg.sv | 27 ++
 rtl/tick_prescaler.sv | 27 ++
 rtl/traffic_light_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Shared state codes and lamp bit positions for the intersection controller.
package traffic_pkg;

  localparam logic [2:0] ST_A_GREEN  = 3'd0;
  localparam logic [2:0] ST_A_ORANGE = 3'd1;
  localparam logic [2:0] ST_RED_AB   = 3'd2;
  localparam logic [2:0] ST_B_GREEN  = 3'd3;
  localparam logic [2:0] ST_B_ORANGE = 3'd4;
  localparam logic [2:0] ST_RED_BA   = 3'd5;
  localparam logic [2:0] ST_FLASH    = 3'd6;

  typedef enum logic [2:0] {
    A_GREEN  = ST_A_GREEN,
    A_ORANGE = ST_A_ORANGE,
    RED_AB   = ST_RED_AB,
    B_GREEN  = ST_B_GREEN,
    B_ORANGE = ST_B_ORANGE,
    RED_BA   = ST_RED_BA,
    FLASH    = ST_FLASH
  } state_e;

  // Bit positions inside a road's {r, o, g} lamp vector.
  localparam int LAMP_R = 2;
  localparam int LAMP_O = 1;
  localparam int LAMP_G = 0;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: one-clk tick pulse every TICK_DIV clocks.
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 50000000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (cnt_q == LAST) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/traffic_light_ctrl.sv
// Timed two-road intersection FSM: min green, gap-out/max-out, orange,
// all-red clearance and a flashing-orange maintenance mode.
module traffic_light_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 50000000,
  parameter int unsigned CNT_W     = 8,
  parameter int unsigned MIN_GREEN = 5,
  parameter int unsigned MAX_GREEN = 20,
  parameter int unsigned ORANGE_T  = 3,
  parameter int unsigned ALLRED_T  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       sa1,
  input  logic       sa2,
  input  logic       sb1,
  input  logic       sb2,
  output logic       a_r,
  output logic       a_o,
  output logic       a_g,
  output logic       b_r,
  output logic       b_o,
  output logic       b_g,
  output logic [2:0] state_o
);

  localparam logic [CNT_W-1:0] MIN_M1 = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAX_M1 = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] ORG_M1 = CNT_W'(ORANGE_T - 1);
  localparam logic [CNT_W-1:0] ARD_M1 = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] T_SAT  = {CNT_W{1'b1}};

  // The enable is carried inverted so that the all-zero reset value of the
  // synchroniser means normal operation rather than an instant flash.
  logic [4:0] sync1_q, sync2_q;
  logic       flash_req, demand_a, demand_b, tick;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {~en, sa1, sa2, sb1, sb2};
      sync2_q <= sync1_q;
    end
  end

  assign flash_req = sync2_q[4];
  assign demand_a  = sync2_q[3] | sync2_q[2];
  assign demand_b  = sync2_q[1] | sync2_q[0];

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk  (clk),
    .rst_n(rst_n),
    .tick (tick)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             blink_q, blink_d;

  always_comb begin
    state_d = state_q;
    if (flash_req) begin
      state_d = FLASH;
    end else begin
      case (state_q)
        A_GREEN:
          if (tick && timer_q >= MIN_M1 && demand_b && (!demand_a || timer_q >= MAX_M1))
            state_d = A_ORANGE;
        A_ORANGE: if (tick && timer_q == ORG_M1) state_d = RED_AB;
        RED_AB:   if (tick && timer_q == ARD_M1) state_d = B_GREEN;
        B_GREEN:
          if (tick && timer_q >= MIN_M1 && demand_a && (!demand_b || timer_q >= MAX_M1))
            state_d = B_ORANGE;
        B_ORANGE: if (tick && timer_q == ORG_M1) state_d = RED_BA;
        RED_BA:   if (tick && timer_q == ARD_M1) state_d = A_GREEN;
        // Leaving maintenance through RED_BA hands the next green to road A.
        FLASH:    state_d = RED_BA;
        default:  state_d = RED_BA;
      endcase
    end
  end

  always_comb begin
    timer_d = timer_q;
    if (state_d != state_q)          timer_d = '0;
    else if (tick && timer_q != T_SAT) timer_d = timer_q + 1'b1;
  end

  // Held at zero outside FLASH, so every flash period starts dark.
  always_comb begin
    blink_d = blink_q;
    if (state_q != FLASH) blink_d = 1'b0;
    else if (tick)        blink_d = ~blink_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= A_GREEN;
      timer_q <= '0;
      blink_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      blink_q <= blink_d;
    end
  end

  logic [2:0] lamp_a, lamp_b;

  always_comb begin
    lamp_a = '0;
    lamp_b = '0;
    case (state_q)
      A_GREEN:  begin lamp_a[LAMP_G] = 1'b1; lamp_b[LAMP_R] = 1'b1; end
      A_ORANGE: begin lamp_a[LAMP_O] = 1'b1; lamp_b[LAMP_R] = 1'b1; end
      B_GREEN:  begin lamp_a[LAMP_R] = 1'b1; lamp_b[LAMP_G] = 1'b1; end
      B_ORANGE: begin lamp_a[LAMP_R] = 1'b1; lamp_b[LAMP_O] = 1'b1; end
      FLASH:    begin lamp_a[LAMP_O] = blink_q; lamp_b[LAMP_O] = blink_q; end
      default:  begin lamp_a[LAMP_R] = 1'b1; lamp_b[LAMP_R] = 1'b1; end
    endcase
  end

  assign {a_r, a_o, a_g} = {lamp_a[LAMP_R], lamp_a[LAMP_O], lamp_a[LAMP_G]};
  assign {b_r, b_o, b_g} = {lamp_b[LAMP_R], lamp_b[LAMP_O], lamp_b[LAMP_G]};
  assign state_o = state_q;

endmodule
